// File: rtl/prach_pkg.sv
// Shared PRACH constants: channel count, HB2 half-band coefficients and the
// hb2 stage latency, plus the round/saturate helper used by the HB2 stages.
package prach_pkg;

    localparam int NUM_CHANNEL = 32;
    localparam int CHN_W       = 8;
    localparam int HB2_LATENCY = 6;

    // fi(1,18,17) half-band coefficients shared with the x2 decimator
    localparam logic signed [17:0] HB2_C0 = -18'sd4249;
    localparam logic signed [17:0] HB2_C1 = 18'sd37013;

    // Takes accumulator bits [35:16] (rounding already added) and clips to 16 bits.
    // The result fits when bits [35:31] are all equal.
    function automatic logic [15:0] hb2_round_sat(input logic [19:0] acc_hi);
        logic [15:0] res;
        if (acc_hi[19:15] == 5'b00000 || acc_hi[19:15] == 5'b11111) begin
            res = acc_hi[15:0];
        end else if (acc_hi[19]) begin
            res = 16'h8000;
        end else begin
            res = 16'h7fff;
        end
        return res;
    endfunction

endpackage

// File: rtl/delay.sv
// Fixed-length register delay line with synchronous active-low clear.
module delay #(
    parameter int WIDTH = 10,
    parameter int DELAY = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DELAY-1:0][WIDTH-1:0] pipe_q;
    logic [DELAY-1:0][WIDTH-1:0] pipe_d;

    // shift one stage per clock; stage 0 takes the new input
    always_comb begin
        pipe_d = {pipe_q[DELAY-2:0], din};
    end

    // delay line storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DELAY-1];

endmodule

// File: rtl/prach_hb2_int_ch.sv
// Channel-interleaved half-band x2 interpolator. Each accepted sample yields the
// FIR phase (dp1) and the center-tap phase (dp2) of the same channel, six clocks
// later, with the dv/chn/sync sideband delayed alongside.
module prach_hb2_int_ch
    import prach_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      din_dq,
    input  logic             din_dv,
    input  logic [CHN_W-1:0] din_chn,
    input  logic             sync_in,
    output logic [15:0]      dout_dp1,
    output logic [15:0]      dout_dp2,
    output logic             dout_dv,
    output logic [CHN_W-1:0] dout_chn,
    output logic             sync_out,
    output logic             err_chn
);

    localparam int                HIST_DEPTH = 3 * NUM_CHANNEL;
    localparam logic signed [35:0] RND       = 36'sd32768;

    // history line: index 0 is newest, so depth k*NUM_CHANNEL is x[m-k] of this channel
    logic [HIST_DEPTH-1:0][15:0] hist_q, hist_d;

    logic signed [15:0] x0_q, x1_q, x2_q, x3_q;
    logic signed [15:0] x0_d, x1_d, x2_d, x3_d;
    logic signed [16:0] pa0_q, pa1_q, pa0_d, pa1_d;
    logic signed [34:0] p0_q, p1_q, p0_d, p1_d;
    logic signed [35:0] acc_full;
    logic        [19:0] acc_hi_q, acc_hi_d;
    logic        [15:0] sat_q, sat_d;
    logic        [15:0] dp1_q, dp1_d;
    logic [4:0][15:0]   dp2_q, dp2_d;
    logic               acc_lsb_unused;

    logic [CHN_W-1:0]   exp_chn_q, exp_chn_d;
    logic               err_q, err_d;

    logic [CHN_W+1:0]   side_out;

    // history advances only on accepted samples
    always_comb begin
        hist_d = hist_q;
        if (din_dv) begin
            hist_d = {hist_q[HIST_DEPTH-2:0], din_dq};
        end
    end

    // datapath: tap capture, pre-add, multiply, sum+round, saturate, output register
    always_comb begin
        x0_d     = din_dq;
        x1_d     = hist_q[NUM_CHANNEL-1];
        x2_d     = hist_q[2*NUM_CHANNEL-1];
        x3_d     = hist_q[HIST_DEPTH-1];
        pa0_d    = 17'(x0_q) + 17'(x3_q);
        pa1_d    = 17'(x1_q) + 17'(x2_q);
        p0_d     = 35'(pa0_q) * 35'(HB2_C0);
        p1_d     = 35'(pa1_q) * 35'(HB2_C1);
        acc_full = 36'(p0_q) + 36'(p1_q) + RND;
        acc_hi_d = acc_full[35:16];
        sat_d    = hb2_round_sat(acc_hi_q);
        dp1_d    = sat_q;
        dp2_d    = {dp2_q[3:0], x1_q};
    end

    // low accumulator bits only matter through the rounding carry
    assign acc_lsb_unused = ^acc_full[15:0];

    // expected-channel tracking; sync on a valid sample is the resync point
    always_comb begin
        exp_chn_d = exp_chn_q;
        err_d     = err_q;
        if (din_dv) begin
            if (sync_in) begin
                exp_chn_d = CHN_W'(1);
                err_d     = 1'b0;
            end else begin
                if (din_chn != exp_chn_q) begin
                    err_d = 1'b1;
                end
                exp_chn_d = (exp_chn_q == CHN_W'(NUM_CHANNEL - 1)) ? '0 : exp_chn_q + CHN_W'(1);
            end
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q    <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            x3_q      <= '0;
            pa0_q     <= '0;
            pa1_q     <= '0;
            p0_q      <= '0;
            p1_q      <= '0;
            acc_hi_q  <= '0;
            sat_q     <= '0;
            dp1_q     <= '0;
            dp2_q     <= '0;
            exp_chn_q <= '0;
            err_q     <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            x3_q      <= x3_d;
            pa0_q     <= pa0_d;
            pa1_q     <= pa1_d;
            p0_q      <= p0_d;
            p1_q      <= p1_d;
            acc_hi_q  <= acc_hi_d;
            sat_q     <= sat_d;
            dp1_q     <= dp1_d;
            dp2_q     <= dp2_d;
            exp_chn_q <= exp_chn_d;
            err_q     <= err_d;
        end
    end

    delay #(
        .WIDTH (CHN_W + 2),
        .DELAY (HB2_LATENCY)
    ) u_side_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({din_dv, sync_in, din_chn}),
        .dout  (side_out)
    );

    assign {dout_dv, sync_out, dout_chn} = side_out;
    assign dout_dp1 = dp1_q;
    assign dout_dp2 = dp2_q[4];
    assign err_chn  = err_q;

endmodule
